// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: CSR file, interrupt synchronizers, trap/MRET redirect FSM.
// Build option: define TRAP_VECTORED_EN to enable vectored interrupt dispatch (mtvec mode 01).
module trap_ctrl #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   input  logic [31:0] pc,
   input  logic        exc_request,
   input  logic        inst_invalid,
   input  logic        exc_ret,
   input  logic [31:0] exc_cause,
   input  logic [1:0]  csr_op,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_wdata,
   input  logic        irq_timer,
   input  logic        irq_ext,
   output logic [31:0] csr_rdata,
   output logic        kill,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc
);

   typedef enum logic {S_RUN, S_REDIRECT} state_t;

`ifdef TRAP_VECTORED_EN
   localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
   localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

   state_t      r_state, w_state_nxt;
   logic        r_mstatus_mie, r_mpie;
   logic        r_mie_mtie, r_mie_meie;
   logic [31:0] r_mtvec, r_mscratch, r_mepc, r_mcause;
   logic [1:0]  r_sync_tmr, r_sync_ext;
   logic [31:0] r_redirect_pc;

   logic        w_mtip, w_meip, w_exc;
   logic        w_trap, w_mret, w_csr_we, w_irq, w_vec;
   logic [31:0] w_cause, w_mtvec_rd, w_mepc_rd, w_csr_new, w_base, w_target;

   assign w_mtip     = r_sync_tmr[1];
   assign w_meip     = r_sync_ext[1];
   assign w_exc      = exc_request | inst_invalid;
   assign w_mtvec_rd = r_mtvec & MTVEC_MASK;
   assign w_mepc_rd  = r_mepc & 32'hFFFF_FFFC;

   always_comb begin
      csr_rdata = '0;
      case (csr_addr)
         12'h300: csr_rdata = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mstatus_mie, 3'd0};
         12'h304: csr_rdata = {20'd0, r_mie_meie, 3'd0, r_mie_mtie, 7'd0};
         12'h305: csr_rdata = w_mtvec_rd;
         12'h340: csr_rdata = r_mscratch;
         12'h341: csr_rdata = w_mepc_rd;
         12'h342: csr_rdata = r_mcause;
         12'h344: csr_rdata = {20'd0, w_meip, 3'd0, w_mtip, 7'd0};
         default: csr_rdata = '0;
      endcase
   end

   always_comb begin
      case (csr_op)
         2'd1:    w_csr_new = csr_wdata;
         2'd2:    w_csr_new = csr_rdata | csr_wdata;
         2'd3:    w_csr_new = csr_rdata & ~csr_wdata;
         default: w_csr_new = csr_rdata;
      endcase
   end

   // Event arbitration and next state; only one event class acts per retiring instruction.
   always_comb begin
      w_state_nxt = r_state;
      w_trap      = 1'b0;
      w_mret      = 1'b0;
      w_csr_we    = 1'b0;
      w_irq       = 1'b0;
      w_cause     = '0;
      case (r_state)
         S_RUN: begin
            if (instr_valid) begin
               if (w_exc) begin
                  w_trap  = 1'b1;
                  w_cause = exc_request ? exc_cause : 32'd2;
               end else if (r_mstatus_mie && r_mie_meie && w_meip) begin
                  w_trap  = 1'b1;
                  w_irq   = 1'b1;
                  w_cause = 32'h8000_000B;
               end else if (r_mstatus_mie && r_mie_mtie && w_mtip) begin
                  w_trap  = 1'b1;
                  w_irq   = 1'b1;
                  w_cause = 32'h8000_0007;
               end else if (exc_ret) begin
                  w_mret = 1'b1;
               end else if (csr_op != 2'd0) begin
                  w_csr_we = 1'b1;
               end
            end
            if (w_trap || w_mret) w_state_nxt = S_REDIRECT;
         end
         S_REDIRECT: w_state_nxt = S_RUN;
         default:    w_state_nxt = S_RUN;
      endcase
   end

   // Mode bits read back as 0 in the non-vectored build, so w_vec can only fire when enabled.
   assign w_vec    = w_irq && (w_mtvec_rd[1:0] == 2'b01);
   assign w_base   = {w_mtvec_rd[31:2], 2'b00};
   assign w_target = w_vec ? (w_base + {w_cause[29:0], 2'b00}) : w_base;

   assign kill           = w_trap;
   assign redirect_valid = (r_state == S_REDIRECT);
   assign redirect_pc    = r_redirect_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_RUN;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mstatus_mie <= 1'b0;
         r_mpie        <= 1'b0;
         r_mie_mtie    <= 1'b0;
         r_mie_meie    <= 1'b0;
         r_mtvec       <= RESET_MTVEC;
         r_mscratch    <= '0;
         r_mepc        <= '0;
         r_mcause      <= '0;
         r_sync_tmr    <= '0;
         r_sync_ext    <= '0;
         r_redirect_pc <= '0;
      end else begin
         r_sync_tmr <= {r_sync_tmr[0], irq_timer};
         r_sync_ext <= {r_sync_ext[0], irq_ext};
         if (w_trap) begin
            r_mepc        <= pc;
            r_mcause      <= w_cause;
            r_mpie        <= r_mstatus_mie;
            r_mstatus_mie <= 1'b0;
            r_redirect_pc <= w_target;
         end else if (w_mret) begin
            r_mstatus_mie <= r_mpie;
            r_mpie        <= 1'b1;
            r_redirect_pc <= w_mepc_rd;
         end else if (w_csr_we) begin
            case (csr_addr)
               12'h300: begin
                  r_mstatus_mie <= w_csr_new[3];
                  r_mpie        <= w_csr_new[7];
               end
               12'h304: begin
                  r_mie_mtie <= w_csr_new[7];
                  r_mie_meie <= w_csr_new[11];
               end
               12'h305: r_mtvec    <= w_csr_new & MTVEC_MASK;
               12'h340: r_mscratch <= w_csr_new;
               12'h341: r_mepc     <= w_csr_new;
               12'h342: r_mcause   <= w_csr_new;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios then randomized traffic against a
// behavioural model. Honours TRAP_VECTORED_EN for the expected interrupt targets.
module tb_trap_ctrl;

   localparam logic [31:0] RST_VEC = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_valid, exc_request, inst_invalid, exc_ret, irq_timer, irq_ext;
   logic [31:0] pc, exc_cause, csr_wdata;
   logic [1:0]  csr_op;
   logic [11:0] csr_addr;
   logic [31:0] csr_rdata, redirect_pc;
   logic        kill, redirect_valid;

   always #5 clk = ~clk;

   trap_ctrl #(.RESET_MTVEC(RST_VEC)) dut (
      .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc(pc),
      .exc_request(exc_request), .inst_invalid(inst_invalid), .exc_ret(exc_ret),
      .exc_cause(exc_cause), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
      .irq_timer(irq_timer), .irq_ext(irq_ext), .csr_rdata(csr_rdata), .kill(kill),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // staged stimulus for the next cycle
   logic        t_valid, t_exr, t_inv, t_ret, t_tmr, t_ext;
   logic [31:0] t_pc, t_cause, t_wdata;
   logic [1:0]  t_op;
   logic [11:0] t_addr;

   // architectural model
   logic        m_mie, m_mpie, m_redir;
   logic [31:0] m_ie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_rpc;
   logic        m_ht[2], m_he[2];

   task automatic model_reset();
      m_mie = 0; m_mpie = 0; m_redir = 0; m_ie = 0; m_mtvec = RST_VEC;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_rpc = 0;
      m_ht[0] = 0; m_ht[1] = 0; m_he[0] = 0; m_he[1] = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
         12'h304: return m_ie;
         12'h305: return m_mtvec;
         12'h340: return m_mscratch;
         12'h341: return m_mepc & ~32'h3;
         12'h342: return m_mcause;
         12'h344: return (32'(m_he[1]) << 11) | (32'(m_ht[1]) << 7);
         default: return 32'h0;
      endcase
   endfunction

   task automatic m_write(input logic [11:0] a, input logic [31:0] v);
      case (a)
         12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
         12'h304: m_ie = v & 32'h880;
`ifdef TRAP_VECTORED_EN
         12'h305: m_mtvec = v & ~32'h2;
`else
         12'h305: m_mtvec = v & ~32'h3;
`endif
         12'h340: m_mscratch = v;
         12'h341: m_mepc = v;
         12'h342: m_mcause = v;
         default: ;
      endcase
   endtask

   task automatic idle_t();
      t_valid = 0; t_exr = 0; t_inv = 0; t_ret = 0; t_pc = 0; t_cause = 0;
      t_op = 0; t_addr = 0; t_wdata = 0;
   endtask

   task automatic apply();
      instr_valid = t_valid; exc_request = t_exr; inst_invalid = t_inv; exc_ret = t_ret;
      pc = t_pc; exc_cause = t_cause; csr_op = t_op; csr_addr = t_addr; csr_wdata = t_wdata;
      irq_timer = t_tmr; irq_ext = t_ext;
   endtask

   // One clock: drive staged inputs, compare all outputs to the model, advance the model.
   task automatic cycle();
      logic trap, irq, nxt;
      logic [31:0] cause, rd, nv, base;
      @(negedge clk);
      apply();
      #1;
      trap = 0; irq = 0; cause = 0; nxt = 0;
      if (!m_redir && t_valid) begin
         if (t_exr || t_inv) begin
            trap = 1; cause = t_exr ? t_cause : 32'd2;
         end else if (m_mie && m_ie[11] && m_he[1]) begin
            trap = 1; irq = 1; cause = 32'h8000_000B;
         end else if (m_mie && m_ie[7] && m_ht[1]) begin
            trap = 1; irq = 1; cause = 32'h8000_0007;
         end
      end
      rd = m_read(t_addr);
      check("kill", 32'(kill), 32'(trap));
      check("csr_rdata", csr_rdata, rd);
      check("redirect_valid", 32'(redirect_valid), 32'(m_redir));
      check("redirect_pc", redirect_pc, m_rpc);
      if (trap) begin
         m_mepc = t_pc; m_mcause = cause; m_mpie = m_mie; m_mie = 0;
         base = m_mtvec & ~32'h3;
         m_rpc = (irq && m_mtvec[1:0] == 2'b01) ? base + ((cause & 32'h7FFF_FFFF) << 2) : base;
         nxt = 1;
      end else if (!m_redir && t_valid && t_ret) begin
         m_mie = m_mpie; m_mpie = 1; m_rpc = m_mepc & ~32'h3; nxt = 1;
      end else if (!m_redir && t_valid && t_op != 2'd0) begin
         nv = (t_op == 2'd1) ? t_wdata : (t_op == 2'd2) ? (rd | t_wdata) : (rd & ~t_wdata);
         m_write(t_addr, nv);
      end
      m_redir = nxt;
      m_ht[1] = m_ht[0]; m_ht[0] = t_tmr;
      m_he[1] = m_he[0]; m_he[0] = t_ext;
   endtask

   task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] v);
      idle_t(); t_valid = 1; t_op = op; t_addr = a; t_wdata = v;
      cycle();
      idle_t();
   endtask

   localparam logic [11:0] ADDRS[9] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                                        12'h342, 12'h344, 12'h301, 12'h7C0};

   initial begin
      rst = 1; t_tmr = 0; t_ext = 0; idle_t(); apply(); model_reset();
      repeat (2) @(negedge clk);
      #1;
      check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
      check("rst_redirect_pc", redirect_pc, 32'd0);
      csr_addr = 12'h305; #1;
      check("rst_mtvec", csr_rdata, RST_VEC);
      csr_addr = 12'h300; #1;
      check("rst_mstatus", csr_rdata, 32'h1800);
      csr_addr = 12'h304; #1;
      check("rst_mie", csr_rdata, 32'h0);
      rst = 0;

      // illegal instruction trap
      csr(2'd1, 12'h305, 32'h200);
      t_valid = 1; t_inv = 1; t_pc = 32'h40; cycle();
      check("ill_kill", 32'(kill), 32'd1);
      idle_t(); t_addr = 12'h341; cycle();
      check("ill_rvalid", 32'(redirect_valid), 32'd1);
      check("ill_rpc", redirect_pc, 32'h200);
      check("ill_mepc", csr_rdata, 32'h40);
      t_addr = 12'h342; cycle();
      check("ill_mcause", csr_rdata, 32'd2);
      check("ill_rvalid_low", 32'(redirect_valid), 32'd0);

      // timer interrupt then MRET
      csr(2'd2, 12'h300, 32'h8);
      csr(2'd2, 12'h304, 32'h80);
      t_tmr = 1; cycle(); cycle();
      t_valid = 1; t_pc = 32'h80; t_addr = 12'h344; cycle();
      check("tmr_mip", csr_rdata, 32'h80);
      check("tmr_kill", 32'(kill), 32'd1);
      t_tmr = 0; idle_t(); t_addr = 12'h342; cycle();
      check("tmr_mcause", csr_rdata, 32'h8000_0007);
      t_addr = 12'h300; cycle();
      check("tmr_mstatus", csr_rdata, 32'h1880);
      idle_t(); cycle();
      t_valid = 1; t_ret = 1; cycle();
      check("mret_kill", 32'(kill), 32'd0);
      idle_t(); t_addr = 12'h300; cycle();
      check("mret_rpc", redirect_pc, 32'h80);
      check("mret_mstatus", csr_rdata, 32'h1888);

      // exception beats a simultaneous external interrupt
      csr(2'd2, 12'h304, 32'h800);
      t_ext = 1; cycle(); cycle();
      t_valid = 1; t_exr = 1; t_cause = 32'd11; cycle();
      check("prio_kill", 32'(kill), 32'd1);
      idle_t(); t_addr = 12'h342; cycle();
      check("prio_mcause", csr_rdata, 32'd11);
      t_addr = 12'h344; cycle();
      check("prio_mip", csr_rdata, 32'h800);
      t_ext = 0; idle_t(); cycle(); cycle();

      // set/clear on mie, and a CSR op dropped by a same-cycle exception
      csr(2'd1, 12'h304, 32'h0);
      csr(2'd2, 12'h304, 32'h880);
      csr(2'd3, 12'h304, 32'h80);
      t_addr = 12'h304; cycle();
      check("mie_setclr", csr_rdata, 32'h800);
      t_valid = 1; t_exr = 1; t_cause = 32'd3; t_op = 2'd1; t_addr = 12'h304;
      t_wdata = 32'hFFFF_FFFF; cycle();
      idle_t(); t_addr = 12'h304; cycle();
      check("mie_discard", csr_rdata, 32'h800);

      // external interrupt with mtvec mode bits set, then reset mid-redirect
      csr(2'd1, 12'h305, 32'h301);
      csr(2'd2, 12'h300, 32'h8);
      t_ext = 1; cycle(); cycle();
      t_valid = 1; t_pc = 32'h1234; cycle();
      check("vec_kill", 32'(kill), 32'd1);
      @(posedge clk); #2;
      check("vec_rvalid", 32'(redirect_valid), 32'd1);
`ifdef TRAP_VECTORED_EN
      check("vec_rpc", redirect_pc, 32'h32C);
`else
      check("vec_rpc", redirect_pc, 32'h300);
`endif
      rst = 1; #1;
      check("arst_rvalid", 32'(redirect_valid), 32'd0);
      check("arst_rpc", redirect_pc, 32'd0);
      t_ext = 0; idle_t(); apply(); model_reset();
      @(negedge clk); rst = 0;
      t_addr = 12'h305; cycle();
      check("arst_mtvec", csr_rdata, RST_VEC);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         idle_t();
         t_valid = ($urandom_range(0, 9) < 7);
         t_pc    = $urandom;
         t_exr   = ($urandom_range(0, 19) == 0);
         t_inv   = ($urandom_range(0, 19) == 0);
         t_ret   = ($urandom_range(0, 11) == 0);
         t_cause = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 15));
         t_op    = 2'($urandom_range(0, 3));
         t_addr  = ADDRS[$urandom_range(0, 8)];
         t_wdata = ($urandom_range(0, 1) == 1) ? $urandom : 32'h888;
         if ($urandom_range(0, 15) == 0) t_tmr = ~t_tmr;
         if ($urandom_range(0, 15) == 0) t_ext = ~t_ext;
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
